add_arb2: RTL and testbench

ADD_ARB2 -- requirements
Module: add_arb2

---
 rtl/add_arb2_pkg.sv | 24 ++
 rtl/rca16.sv | 39 +++
 rtl/add_arb2.sv | 137 +++++++++++++
 tb/tb_add_arb2.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/add_arb2_pkg.sv
// Shared types for the two-requester arbitrated adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package add_arb2_pkg;

    // Requester identifier: 0 or 1.
    typedef logic id_t;

    // One entry of the in-flight tag pipeline. It tracks which requester owns
    // the adder result that is moving through the pipeline alongside it.
    typedef struct packed {
        logic vld;
        id_t  id;
    } tag_t;

    // Number of clock edges rca16 takes from sampling operands to a stable sum.
    localparam int RCA16_LAT = 2;

    // Converts a requester id to its bit in a 2-bit per-requester vector.
    function automatic logic [1:0] id_onehot(input id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rca16.sv
// Two-stage pipelined ripple-carry adder: {cout, s} = a + b + cin.
// Latency: 2 edges. Operands are sampled at edge 1 and the sum is stable after edge 2.
// Backpressure: none. A new operand set is taken every cycle.
// Ports: clk, rst_b (async active-low), a/b/cin operands, s/cout registered result.
module rca16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         cin_q;
    logic [W:0]   sum_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            sum_q <= '0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            cin_q <= cin;
            sum_q <= {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        end
    end

    assign s    = sum_q[W-1:0];
    assign cout = sum_q[W];

endmodule

// File: rtl/add_arb2.sv
// Round-robin arbiter that shares one pipelined adder between two requesters.
// Latency: LAT edges from accept to the rsp_valid strobe, with one accept per cycle and no bubbles.
// Backpressure: none beyond arbitration. A losing requester must hold req_valid itself because nothing is queued.
// Ports: clk, rst_b (async active-low); req_valid/req_ready[1:0]; req_a*/req_b*/req_cin* operands;
//        rsp_valid[1:0], rsp_s, rsp_cout shared result; busy. Optional macro ADD_ARB2_STATS_EN
//        adds gnt_cnt0/gnt_cnt1 saturating accept counters.
module add_arb2
    import add_arb2_pkg::*;
#(
    parameter int W   = 16,
    parameter int LAT = 2   // must equal RCA16_LAT; the tag pipe tracks the adder stages
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic         req_cin0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    input  logic         req_cin1,
    output logic [1:0]   rsp_valid,
    output logic [W-1:0] rsp_s,
    output logic         rsp_cout,
    output logic         busy
`ifdef ADD_ARB2_STATS_EN
    ,
    output logic [15:0]  gnt_cnt0,
    output logic [15:0]  gnt_cnt1
`endif
);

    localparam int CW = $clog2(LAT + 1);

    id_t          ptr_q;
    logic [1:0]   gnt;
    id_t          gnt_id;
    logic         accept;
    logic         retire;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    tag_t         tag_q [LAT];
    logic [CW-1:0] cnt_q;

    // Grant logic. The grant is forced to zero during reset, so req_ready stays
    // low even before the first edge has cleared any state.
    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (rst_b) begin
            unique case (req_valid)
                2'b01: begin gnt = 2'b01;            gnt_id = 1'b0;  end
                2'b10: begin gnt = 2'b10;            gnt_id = 1'b1;  end
                2'b11: begin gnt = id_onehot(ptr_q); gnt_id = ptr_q; end
                default: ;
            endcase
        end
    end

    assign req_ready = gnt;
    assign accept    = |gnt;

    // The adder sees zeros when there is no grant, so idle cycles do not toggle it.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (gnt[0]) begin
            add_a = req_a0; add_b = req_b0; add_cin = req_cin0;
        end else if (gnt[1]) begin
            add_a = req_a1; add_b = req_b1; add_cin = req_cin1;
        end
    end

    rca16 #(.W(W)) u_rca16 (
        .clk   (clk),
        .rst_b (rst_b),
        .a     (add_a),
        .b     (add_b),
        .cin   (add_cin),
        .s     (rsp_s),
        .cout  (rsp_cout)
    );

    // The pointer moves only on real contention. A lone requester never
    // steals the other requester's next turn.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q <= 1'b0;
        end else if (req_valid == 2'b11) begin
            ptr_q <= ~ptr_q;
        end
    end

    // The tag pipeline runs in lockstep with the adder stages. Its last entry
    // marks the cycle in which rsp_s and rsp_cout belong to a requester.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{vld: accept, id: gnt_id};
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign retire    = tag_q[LAT-1].vld;
    assign rsp_valid = retire ? id_onehot(tag_q[LAT-1].id) : 2'b00;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            unique case ({accept, retire})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    assign busy = (cnt_q != '0);

`ifdef ADD_ARB2_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt[0] && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt[1] && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_add_arb2.sv
// Testbench for add_arb2: scoreboard of expected responses plus a reference arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_add_arb2;

    localparam int W   = 16;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic         req_cin0, req_cin1;
    logic [1:0]   rsp_valid;
    logic [W-1:0] rsp_s;
    logic         rsp_cout;
    logic         busy;
`ifdef ADD_ARB2_STATS_EN
    logic [15:0]  gnt_cnt0, gnt_cnt1;
`endif

    add_arb2 #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_cin0  (req_cin0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_cin1  (req_cin1),
        .rsp_valid (rsp_valid),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
`ifdef ADD_ARB2_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int           due;
        logic [1:0]   vld;
        logic [W-1:0] s;
        logic         cout;
    } exp_t;

    exp_t sb[$];
    logic mptr;
    int   mcnt0, mcnt1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model and scoreboard, evaluated mid-cycle while inputs and outputs are stable.
    always @(negedge clk) begin
        logic [1:0] erdy;
        logic [W:0] sum;
        exp_t       e;
        if (!rst_b) begin
            sb.delete();
            mptr  = 1'b0;
            mcnt0 = 0;
            mcnt1 = 0;
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
        end else begin
            chk("busy", busy, sb.size() != 0);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, e.vld);
                chk("rsp_s", rsp_s, e.s);
                chk("rsp_cout", rsp_cout, e.cout);
            end else if (rsp_valid != 2'b00) begin
                chk("spurious_rsp", rsp_valid, 0);
            end

            case (req_valid)
                2'b01:   erdy = 2'b01;
                2'b10:   erdy = 2'b10;
                2'b11:   erdy = mptr ? 2'b10 : 2'b01;
                default: erdy = 2'b00;
            endcase
            chk("req_ready", req_ready, erdy);
            if (erdy != 2'b00) begin
                if (erdy[0]) begin
                    sum = {1'b0, req_a0} + {1'b0, req_b0} + {{W{1'b0}}, req_cin0};
                    mcnt0++;
                end else begin
                    sum = {1'b0, req_a1} + {1'b0, req_b1} + {{W{1'b0}}, req_cin1};
                    mcnt1++;
                end
                e.due  = cyc + LAT;
                e.vld  = erdy;
                e.s    = sum[W-1:0];
                e.cout = sum[W];
                sb.push_back(e);
            end
            if (req_valid == 2'b11) mptr = ~mptr;
        end
    end

    // Inputs change 1 time unit after the rising edge and are held for one cycle.
    task automatic drive(input logic [1:0] v,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1);
        req_valid = v;
        req_a0 = a0; req_b0 = b0; req_cin0 = c0;
        req_a1 = a1; req_b1 = b1; req_cin1 = c1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_b = 1'b0;
        idle(2);
        rst_b = 1'b1;
    endtask

    initial begin
        // Keep both requests high during reset so that forcing req_ready low is exercised.
        rst_b     = 1'b0;
        req_valid = 2'b11;
        req_a0 = 16'h1111; req_b0 = 16'h2222; req_cin0 = 1'b1;
        req_a1 = 16'h3333; req_b1 = 16'h4444; req_cin1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Single request: 0x0000 + 0xFFFF + 1 gives s=0x0000 and cout=1.
        drive(2'b01, 16'h0000, 16'hFFFF, 1'b1, '0, '0, 1'b0);
        idle(4);

        // Contention straight after reset: grants go 0,1,0,1.
        pulse_reset();
        for (int i = 0; i < 4; i++)
            drive(2'b11, 16'(16'h0100 + i), 16'h0001, 1'b0, 16'(16'h0200 + i), 16'h0002, 1'b1);
        idle(4);

        // Requester 1 streams back to back, with no bubbles.
        for (int i = 1; i <= 4; i++)
            drive(2'b10, '0, '0, 1'b0, 16'(i), 16'h0010, 1'b0);
        idle(4);

        // Sum wraps modulo 2^W.
        drive(2'b01, 16'hFFFF, 16'h0001, 1'b0, '0, '0, 1'b0);
        drive(2'b10, '0, '0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(4);

        // Reset asserted right after an accept. The in-flight result must never appear.
        drive(2'b01, 16'h0005, 16'h0006, 1'b0, '0, '0, 1'b0);
        rst_b = 1'b0;
        idle(3);
        rst_b = 1'b1;
        idle(4);

        // Random traffic, including single requests that must leave the pointer unchanged.
        for (int i = 0; i < 300; i++)
            drive(2'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom));
        idle(4);

`ifdef ADD_ARB2_STATS_EN
        pulse_reset();
        for (int i = 0; i < 70000; i++)
            drive(2'b01, 16'(i), 16'h0003, 1'b0, '0, '0, 1'b0);
        idle(4);
        chk("gnt_cnt0_sat", gnt_cnt0, 16'hFFFF);
        chk("gnt_cnt1", gnt_cnt1, (mcnt1 > 65535) ? 65535 : mcnt1);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
